// File: rtl/mux_arbiter.sv
// mux_arbiter: two-source round-robin arbiter with burst limit feeding a
// single-entry registered output stage.
module mux_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] x,
   input  logic             x_valid,
   output logic             x_ready,
   input  logic [WIDTH-1:0] y,
   input  logic             y_valid,
   output logic             y_ready,
   output logic             s,
   output logic [WIDTH-1:0] m,
   output logic             m_valid,
   input  logic             m_ready
);
   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] CMAX = CW'(MAX_BURST - 1);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GRANT_X = 2'd1;
   localparam logic [1:0] GRANT_Y = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic             m_valid_q, m_valid_d;
   logic             space, is_y, own_v, oth_v, xfer;
   logic [1:0]       oth_st;

   assign space   = !m_valid_q || m_ready;
   assign is_y    = state_q == GRANT_Y;
   assign x_ready = (state_q == GRANT_X) && space;
   assign y_ready = is_y && space;
   assign s       = is_y;
   assign m       = m_q;
   assign m_valid = m_valid_q;
   assign own_v   = is_y ? y_valid : x_valid;
   assign oth_v   = is_y ? x_valid : y_valid;
   assign oth_st  = is_y ? GRANT_X : GRANT_Y;
   assign xfer    = (x_valid && x_ready) || (y_valid && y_ready);
   assign m_d       = xfer ? (is_y ? y : x) : m_q;
   assign m_valid_d = xfer || (m_valid_q && !m_ready);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (x_valid && y_valid) state_d = last_q ? GRANT_X : GRANT_Y;
            else if (x_valid) state_d = GRANT_X;
            else if (y_valid) state_d = GRANT_Y;
         end
         GRANT_X, GRANT_Y: begin
            if (xfer) begin
               // burst limit only hands over when the other side is waiting
               if (cnt_q == CMAX) begin
                  cnt_d = '0;
                  if (oth_v) begin
                     state_d = oth_st;
                     last_d  = is_y;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else if (!own_v) begin
               cnt_d   = '0;
               last_d  = is_y;
               state_d = oth_v ? oth_st : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         m_q       <= '0;
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         m_q       <= m_d;
         m_valid_q <= m_valid_d;
      end
   end
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: vector table, directed sequences and random traffic checked
// against a grant-ownership reference model.
module tb_mux_arbiter;
   localparam int MB = 4;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [7:0] x = '0, y = '0, m;
   logic       x_valid = 1'b0, y_valid = 1'b0, m_ready = 1'b0;
   logic       x_ready, y_ready, s, m_valid;
   int total = 0, bad = 0;
   int own, burst, lst, mv;
   logic [7:0] mm;
   logic lx, ly;

   mux_arbiter #(.WIDTH(8), .MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .x_ready(x_ready),
      .y(y), .y_valid(y_valid), .y_ready(y_ready), .s(s), .m(m),
      .m_valid(m_valid), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic xv; logic [7:0] xd; logic yv; logic [7:0] yd; logic mr;
      logic exr; logic eyr; logic es; logic emv; logic [7:0] em;
   } vec_t;
   vec_t tv[18];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      own = 0; burst = 0; lst = 1; mv = 0; mm = '0; lx = 0; ly = 0;
   endtask

   // own: 0 none, 1 x holds grant, 2 y holds grant; lst: 0 x, 1 y served last
   task automatic step(input logic xv, input logic [7:0] xd, input logic yv,
                       input logic [7:0] yd, input logic mr);
      int sp, ov, ot;
      @(negedge clk);
      x_valid = xv; x = xd; y_valid = yv; y = yd; m_ready = mr;
      #1;
      sp = (mv == 0 || mr) ? 1 : 0;
      chk("x_ready", x_ready, (own == 1) ? sp : 0);
      chk("y_ready", y_ready, (own == 2) ? sp : 0);
      chk("s", s, (own == 2) ? 1 : 0);
      chk("m_valid", m_valid, mv);
      chk("m", m, mm);
      lx = (own == 1) && xv && sp;
      ly = (own == 2) && yv && sp;
      if (lx || ly) begin
         mm = lx ? xd : yd;
         mv = 1;
      end else if (mr) mv = 0;
      if (own == 0) begin
         burst = 0;
         if (xv && yv) own = (lst == 1) ? 1 : 2;
         else if (xv) own = 1;
         else if (yv) own = 2;
      end else begin
         ov = (own == 1) ? xv : yv;
         ot = (own == 1) ? yv : xv;
         if (lx || ly) begin
            burst++;
            if (burst == MB) begin
               burst = 0;
               if (ot != 0) begin lst = own - 1; own = 3 - own; end
            end
         end else if (ov == 0) begin
            burst = 0;
            lst = own - 1;
            own = (ot != 0) ? 3 - own : 0;
         end
      end
   endtask

   initial begin
      logic cxv, cyv, mr;
      logic [7:0] cxd, cyd;
      int nacc;
      //          xv  xd     yv  yd     mr  xr  yr  s   mv  m
      tv[0]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00};
      tv[1]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00};
      tv[2]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00};
      tv[3]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00};
      tv[4]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00};
      tv[5]  = '{1, 8'h11, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00};
      tv[6]  = '{1, 8'h11, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00};
      tv[7]  = '{1, 8'h12, 0, 8'h00, 1, 1, 0, 0, 1, 8'h11};
      tv[8]  = '{1, 8'h13, 0, 8'h00, 1, 1, 0, 0, 1, 8'h12};
      tv[9]  = '{1, 8'h14, 1, 8'hA1, 1, 1, 0, 0, 1, 8'h13};
      tv[10] = '{1, 8'h15, 1, 8'hA1, 1, 0, 1, 1, 1, 8'h14};
      tv[11] = '{1, 8'h15, 1, 8'hA2, 0, 0, 0, 1, 1, 8'hA1};
      tv[12] = '{1, 8'h15, 1, 8'hA2, 0, 0, 0, 1, 1, 8'hA1};
      tv[13] = '{1, 8'h15, 1, 8'hA2, 1, 0, 1, 1, 1, 8'hA1};
      tv[14] = '{1, 8'h15, 0, 8'h00, 1, 0, 1, 1, 1, 8'hA2};
      tv[15] = '{1, 8'h15, 0, 8'h00, 1, 1, 0, 0, 0, 8'hA2};
      tv[16] = '{0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, 8'h15};
      tv[17] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h15};
      model_reset();
      #12 rst_n = 1'b1;
      for (int i = 0; i < 18; i++) begin
         step(tv[i].xv, tv[i].xd, tv[i].yv, tv[i].yd, tv[i].mr);
         chk("tbl_x_ready", x_ready, tv[i].exr);
         chk("tbl_y_ready", y_ready, tv[i].eyr);
         chk("tbl_s", s, tv[i].es);
         chk("tbl_m_valid", m_valid, tv[i].emv);
         chk("tbl_m", m, tv[i].em);
      end
      // ten back-to-back x beats from idle
      nacc = 0;
      for (int c = 0; c < 14; c++) begin
         step(nacc < 10, 8'(8'h11 + nacc), 1'b0, 8'h00, 1'b1);
         if (c == 2) chk("stream_first_m", m, 8'h11);
         if (lx) nacc++;
      end
      chk("stream_count", nacc, 10);
      // x served last, so a tie from idle goes to y
      step(1'b1, 8'h30, 1'b1, 8'h40, 1'b1);
      step(1'b1, 8'h30, 1'b1, 8'h40, 1'b1);
      chk("tie_after_x_s", s, 1);
      step(1'b1, 8'h30, 1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h30, 1'b0, 8'h00, 1'b1);
      chk("drop_y_grants_x", x_ready, 1);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      // random traffic obeying the hold-until-accepted source rule
      cxv = 0; cyv = 0; cxd = '0; cyd = '0;
      for (int c = 0; c < 2000; c++) begin
         if (!cxv || lx) begin cxv = $urandom_range(0, 3) != 0; cxd = 8'($urandom); end
         if (!cyv || ly) begin cyv = $urandom_range(0, 3) != 0; cyd = 8'($urandom); end
         mr = (c > 1000 && c < 1300) ? 1'b1 : ($urandom_range(0, 3) != 0);
         step(cxv, cxd, cyv, cyd, mr);
      end
      for (int c = 0; c < 20 && mv == 0; c++) begin
         if (!cxv || lx) begin cxv = 1'b1; cxd = 8'($urandom); end
         if (!cyv || ly) begin cyv = 1'b1; cyd = 8'($urandom); end
         step(cxv, cxd, cyv, cyd, 1'b0);
      end
      chk("pre_reset_m_valid", m_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m", m, 0);
      chk("rst_s", s, 0);
      chk("rst_x_ready", x_ready, 0);
      chk("rst_y_ready", y_ready, 0);
      x_valid = 1'b0; y_valid = 1'b0;
      #1 rst_n = 1'b1;
      model_reset();
      cxv = 0; cyv = 0;
      for (int c = 0; c < 300; c++) begin
         if (!cxv || lx) begin cxv = $urandom_range(0, 2) != 0; cxd = 8'($urandom); end
         if (!cyv || ly) begin cyv = $urandom_range(0, 2) != 0; cyd = 8'($urandom); end
         step(cxv, cxd, cyv, cyd, $urandom_range(0, 3) != 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
